// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory behind the MEM stage of the 16-bit core.
// Valid/ready request port, byte-lane stores, registered response port and an
// automatic clear sequence that zeroes every word after reset.
// Optional feature macro: DMEM_CLAMP_EN -- when defined, out-of-range accesses
// are redirected to the last word instead of being dropped / returning zero.
module dmem_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 500
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VALID,
    input  logic                REQ_WRITE,
    input  logic [ADDR_W-1:0]   REQ_ADDR,
    input  logic [DATA_W-1:0]   REQ_DATA,
    input  logic [DATA_W/8-1:0] REQ_BE,
    output logic                REQ_READY,
    output logic                RSP_VALID,
    output logic [DATA_W-1:0]   RSP_DATA,
    output logic                RSP_ERR,
    output logic                INIT_BUSY
);

    localparam int                BE_W      = DATA_W / 8;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  mem_r [DEPTH];

    logic               accept_s;
    logic               in_range_s;
    logic               store_ok_s;
    logic [IDX_W-1:0]   idx_s;
    logic [DATA_W-1:0]  rd_word_s;
    logic [DATA_W-1:0]  merged_s;
    logic [DATA_W-1:0]  rsp_word_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_idx_s;
    logic [DATA_W-1:0]  mem_wdata_s;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Request decode, read-modify-write merge and memory write-port selection.
    always_comb begin
        accept_s    = RST && REQ_VALID && REQ_READY && (state_r == ST_RUN);
        // Range check at full address width so high bits are never ignored.
        in_range_s  = ({1'b0, REQ_ADDR} < DEPTH_EXT);
`ifdef DMEM_CLAMP_EN
        idx_s       = in_range_s ? REQ_ADDR[IDX_W-1:0] : LAST_IDX;
        store_ok_s  = 1'b1;
`else
        // Out-of-range index is parked at 0 only to keep the read in bounds.
        idx_s       = in_range_s ? REQ_ADDR[IDX_W-1:0] : {IDX_W{1'b0}};
        store_ok_s  = in_range_s;
`endif
        rd_word_s   = mem_r[idx_s];
        if (REQ_WRITE) begin
            merged_s = merge_lanes(rd_word_s, REQ_DATA, REQ_BE);
        end else begin
            merged_s = rd_word_s;
        end
        if (store_ok_s) begin
            rsp_word_s = merged_s;
        end else begin
            rsp_word_s = {DATA_W{1'b0}};
        end
        if (RST && (state_r == ST_CLEAR)) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = cnt_r;
            mem_wdata_s = {DATA_W{1'b0}};
        end else if (accept_s && REQ_WRITE && store_ok_s) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = idx_s;
            mem_wdata_s = merged_s;
        end else begin
            mem_we_s    = 1'b0;
            mem_idx_s   = idx_s;
            mem_wdata_s = merged_s;
        end
    end

    // Storage array: single write port shared by the clear sequencer and stores.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    // Control FSM with registered handshake, response and status outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r   <= ST_CLEAR;
            cnt_r     <= {IDX_W{1'b0}};
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= {DATA_W{1'b0}};
            RSP_ERR   <= 1'b0;
            INIT_BUSY <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    RSP_VALID <= 1'b0;
                    cnt_r     <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_IDX) begin
                        state_r   <= ST_RUN;
                        REQ_READY <= 1'b1;
                        INIT_BUSY <= 1'b0;
                    end else begin
                        REQ_READY <= 1'b0;
                        INIT_BUSY <= 1'b1;
                    end
                end
                ST_RUN: begin
                    REQ_READY <= 1'b1;
                    INIT_BUSY <= 1'b0;
                    RSP_VALID <= accept_s;
                    if (accept_s) begin
                        RSP_DATA <= rsp_word_s;
                        RSP_ERR  <= ~in_range_s;
                    end else begin
                        RSP_DATA <= RSP_DATA;
                        RSP_ERR  <= RSP_ERR;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    cnt_r     <= {IDX_W{1'b0}};
                    REQ_READY <= 1'b0;
                    RSP_VALID <= 1'b0;
                    INIT_BUSY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised single-port data memory with a valid/ready request interface, byte-lane writes, a registered read port and an automatic post-reset clear sequencer. It sits behind the MEM stage of the 16-bit core and serves loads and stores from the pipeline. Out-of-range accesses are flagged rather than silently corrupting storage.

## Interface
- DATA_W, 16: word width in bits; must be a multiple of 8.
- ADDR_W, 16: request address width (word-addressed).
- DEPTH, 500: number of words implemented; valid addresses are 0..DEPTH-1.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_WRITE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  ADDR_W  word address.
- REQ_DATA  in  DATA_W  store data.
- REQ_BE  in  DATA_W/8  byte-lane write enables; bit k covers bits 8k+7:8k. Ignored on loads.
- REQ_READY  out  1  block can accept a request this cycle.
- RSP_VALID  out  1  one-cycle pulse: response for the request accepted in the previous cycle.
- RSP_DATA  out  DATA_W  word at the addressed location after any write.
- RSP_ERR  out  1  address was >= DEPTH; qualified by RSP_VALID.
- INIT_BUSY  out  1  clear sequence in progress.

## Operation
- Two-state FSM: CLEAR and RUN.
- Reset (RST=0 at posedge): state <= CLEAR, clear counter <= 0. Outputs: REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, INIT_BUSY=1. Memory is not written while RST=0.
- CLEAR: each cycle with RST=1, write 0 to mem[counter] and increment. The counter is $clog2(DEPTH) bits wide. After writing DEPTH-1, move to RUN. REQ_READY=0 and INIT_BUSY=1 throughout CLEAR.
- RUN: REQ_READY=1 and INIT_BUSY=0. A request is accepted when REQ_VALID && REQ_READY at posedge.
- Store, in range: update only the lanes with REQ_BE[k]=1.
- Load: no state change.
- Every accepted request produces exactly one response on the next cycle, with write-first semantics. RSP_DATA is the full stored word after the merge. A store with REQ_BE=0 still responds with the unchanged word.
- Out-of-range (REQ_ADDR >= DEPTH): RSP_ERR=1, and behaviour follows Configuration. Compare at full ADDR_W width with no truncation before the comparison.
- No response backpressure: the consumer must take RSP_* in the pulse cycle.
- When no request is accepted, RSP_DATA and RSP_ERR hold their previous values.

## Timing
- Load latency is 1 cycle: a request accepted at edge N gives RSP_VALID=1 and data during cycle N→N+1.
- Throughput is one request per cycle; back-to-back accepts are allowed.
- A load issued at N+1 to an address stored at N returns the new data.
- Clear duration: after RST goes high, INIT_BUSY stays 1 for exactly DEPTH cycles. REQ_READY rises in the cycle after the last clear write.
- Reset mid-clear or mid-run: any cycle with RST=0 cancels a pending response (RSP_VALID=0 next cycle) and restarts the clear from address 0 once RST returns high.

## Configuration
- DMEM_CLAMP_EN defined: out-of-range addresses are clamped to DEPTH-1. Stores write mem[DEPTH-1] under REQ_BE, and loads return mem[DEPTH-1]. RSP_ERR=1 in both cases.
- DMEM_CLAMP_EN undefined: out-of-range stores are dropped (no memory change) and loads return RSP_DATA=0. RSP_ERR=1 in both cases.

## Test plan
- Reset, then clear: hold RST=0 for 2 cycles, then release. INIT_BUSY=1 for exactly 500 cycles, then REQ_READY=1. A load of addr 0 and a load of addr 499 each return 0x0000 with RSP_ERR=0.
- Store then load: store 0xBEEF to addr 17 with BE=2'b11, then load addr 17 on the next cycle. Both responses return 0xBEEF.
- Byte lanes: addr 5 holds 0x1234; store 0xABCD with BE=2'b01. Response is 0x12CD. A following store with BE=2'b00 still responds 0x12CD.
- Out-of-range store of 0x5555 to addr 600:
  - Without DMEM_CLAMP_EN: RSP_ERR=1 and RSP_DATA=0, and a load of addr 499 is unchanged.
  - With DMEM_CLAMP_EN: RSP_ERR=1, and addr 499 reads 0x5555.
- Back-to-back: alternate store/load to addrs 1..8 on consecutive cycles. There is one RSP_VALID per accept, in order, each carrying the correct data.
- Reset mid-operation:
  - Assert RST=0 for one cycle during clear at count 200. The clear restarts, and INIT_BUSY lasts a full 500 cycles after release.
  - Assert RST=0 in a cycle following an accepted load. No RSP_VALID is produced.
